// File: rtl/sprite_pkg.sv
// Shared game definitions: direction encodings, the motion FSM state encoding
// and the default movement step.
package sprite_pkg;

    // One-hot direction bits, shared by move_dir and map_moves.
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    localparam int DEFAULT_STEP = 15;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        UPDATE,
        DONE
    } state_t;

endpackage

// File: rtl/sprite_motion_engine_if.sv
// Map lookup handshake: the engine asks which directions are legal at (x, y)
// and the map answers with a one-cycle ack carrying the legal-direction mask.
interface sprite_motion_engine_if #(
    parameter int X_W = 11,
    parameter int Y_W = 10
);
    logic           map_req;
    logic [X_W-1:0] map_x;
    logic [Y_W-1:0] map_y;
    logic           map_ack;
    logic [3:0]     map_moves;

    modport master (
        output map_req, map_x, map_y,
        input  map_ack, map_moves
    );

    modport slave (
        input  map_req, map_x, map_y,
        output map_ack, map_moves
    );
endinterface

// File: rtl/sprite_motion_engine_move_calc.sv
// Combinational next-position calculation for one sprite: legality check,
// step arithmetic, horizontal tunnel wrap and playfield clamping.
module move_calc
    import sprite_pkg::*;
#(
    parameter int X_W    = 11,
    parameter int Y_W    = 10,
    parameter int STEP   = DEFAULT_STEP,
    parameter int X_SPAN = 420,
    parameter int Y_SPAN = 465,
    parameter int WRAP_X = 1
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [3:0]     dir,
    input  logic [3:0]     moves,
    output logic [X_W-1:0] new_x,
    output logic [Y_W-1:0] new_y
);
    // One extra bit so x+STEP and x+X_SPAN never truncate.
    localparam logic [X_W:0] STEP_X = STEP[X_W:0];
    localparam logic [X_W:0] SPAN_X = X_SPAN[X_W:0];
    localparam logic [Y_W:0] STEP_Y = STEP[Y_W:0];
    localparam logic [Y_W:0] SPAN_Y = Y_SPAN[Y_W:0];

    logic [X_W:0] xe, x_r, x_l, nx;
    logic [Y_W:0] ye, y_u, y_d, ny;
    logic         legal;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        xe    = {1'b0, x};
        ye    = {1'b0, y};
        x_r   = xe + STEP_X;
        x_l   = xe - STEP_X;
        y_u   = ye - STEP_Y;
        y_d   = ye + STEP_Y;
        nx    = xe;
        ny    = ye;
        legal = $onehot(dir) && ((dir & moves) != 4'b0000);

        if (legal) begin
            case (dir)
                DIR_RIGHT: begin
                    if (x_r < SPAN_X)     nx = x_r;
                    else if (WRAP_X != 0) nx = x_r - SPAN_X;
                end
                DIR_LEFT: begin
                    if (xe >= STEP_X)     nx = x_l;
                    else if (WRAP_X != 0) nx = xe + SPAN_X - STEP_X;
                end
                DIR_UP:   if (ye >= STEP_Y) ny = y_u;
                DIR_DOWN: if (y_d < SPAN_Y) ny = y_d;
                default: ;
            endcase
        end

        new_x = nx[X_W-1:0];
        new_y = ny[Y_W-1:0];
    end
endmodule

// File: rtl/sprite_motion_engine.sv
// Per-frame sprite motion engine: on each tick, walks every sprite, asks the
// map which directions are legal at its position and applies the requested move.
module sprite_motion_engine
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 5,
    parameter int X_W         = 11,
    parameter int Y_W         = 10,
    parameter int STEP        = DEFAULT_STEP,
    parameter int X_SPAN      = 420,
    parameter int Y_SPAN      = 465,
    parameter int WRAP_X      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [4*NUM_SPRITES-1:0]   move_dir,
    input  logic [X_W*NUM_SPRITES-1:0] init_x,
    input  logic [Y_W*NUM_SPRITES-1:0] init_y,
    sprite_motion_engine_if.master     map_if,
    output logic [X_W*NUM_SPRITES-1:0] pos_x,
    output logic [Y_W*NUM_SPRITES-1:0] pos_y,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);
    localparam int                 IDX_W    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           nxt_idx;
    logic [4*NUM_SPRITES-1:0]   dir_lat;
    logic [3:0]                 moves_lat;
    logic [X_W-1:0]             new_x;
    logic [Y_W-1:0]             new_y;

    assign nxt_idx = idx + 1'b1;

    move_calc #(
        .X_W    (X_W),
        .Y_W    (Y_W),
        .STEP   (STEP),
        .X_SPAN (X_SPAN),
        .Y_SPAN (Y_SPAN),
        .WRAP_X (WRAP_X)
    ) u_move_calc (
        .x     (pos_x[idx*X_W +: X_W]),
        .y     (pos_y[idx*Y_W +: Y_W]),
        .dir   (dir_lat[idx*4 +: 4]),
        .moves (moves_lat),
        .new_x (new_x),
        .new_y (new_y)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // read in this block sees the value from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            dir_lat        <= '0;
            moves_lat      <= '0;
            map_if.map_req <= 1'b0;
            map_if.map_x   <= '0;
            map_if.map_y   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            overrun        <= 1'b0;
            pos_x          <= init_x;
            pos_y          <= init_y;
        end else begin
            done <= 1'b0;
            // A tick anywhere outside IDLE, DONE included, is dropped and flagged.
            if (tick && state != IDLE) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (tick) begin
                        dir_lat        <= move_dir;
                        idx            <= '0;
                        map_if.map_req <= 1'b1;
                        map_if.map_x   <= pos_x[X_W-1:0];
                        map_if.map_y   <= pos_y[Y_W-1:0];
                        busy           <= 1'b1;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (map_if.map_ack && map_if.map_req) begin
                        moves_lat      <= map_if.map_moves;
                        map_if.map_req <= 1'b0;
                        state          <= UPDATE;
                    end
                end
                UPDATE: begin
                    pos_x[idx*X_W +: X_W] <= new_x;
                    pos_y[idx*Y_W +: Y_W] <= new_y;
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx            <= nxt_idx;
                        map_if.map_req <= 1'b1;
                        map_if.map_x   <= pos_x[nxt_idx*X_W +: X_W];
                        map_if.map_y   <= pos_y[nxt_idx*Y_W +: Y_W];
                        state          <= REQ;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_motion_engine.sv
// Directed and randomized bench for sprite_motion_engine; a wrapping and a
// non-wrapping instance run in lockstep against a plain-arithmetic position model.
module tb_sprite_motion_engine;
    localparam int NS   = 5;
    localparam int XW   = 11;
    localparam int YW   = 10;
    localparam int STEP = 15;
    localparam int XS   = 420;
    localparam int YS   = 465;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tick = 1'b0;
    logic [4*NS-1:0]   move_dir = '0;
    logic [XW*NS-1:0]  init_x = '0;
    logic [YW*NS-1:0]  init_y = '0;
    logic              ack = 1'b0;
    logic [3:0]        moves = 4'b0000;

    logic [XW*NS-1:0]  pos_x [2];
    logic [YW*NS-1:0]  pos_y [2];
    logic              busy_o [2];
    logic              done_o [2];
    logic              ovr_o [2];
    logic              req_o [2];
    logic [XW-1:0]     mx_o [2];
    logic [YW-1:0]     my_o [2];

    // Model state: index 0 is the wrapping instance, index 1 the non-wrapping one.
    int          mpx [2][NS];
    int          mpy [2][NS];
    int          ix [NS];
    int          iy [NS];
    logic [3:0]  dir_a [NS];
    logic [3:0]  mv_a [NS];
    int          dly [NS];
    bit          exp_ovr;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    sprite_motion_engine_if #(.X_W(XW), .Y_W(YW)) mif0 ();
    sprite_motion_engine_if #(.X_W(XW), .Y_W(YW)) mif1 ();

    assign mif0.map_ack   = ack;
    assign mif0.map_moves = moves;
    assign mif1.map_ack   = ack;
    assign mif1.map_moves = moves;
    assign req_o[0] = mif0.map_req;
    assign req_o[1] = mif1.map_req;
    assign mx_o[0]  = mif0.map_x;
    assign mx_o[1]  = mif1.map_x;
    assign my_o[0]  = mif0.map_y;
    assign my_o[1]  = mif1.map_y;

    sprite_motion_engine #(
        .NUM_SPRITES(NS), .X_W(XW), .Y_W(YW), .STEP(STEP),
        .X_SPAN(XS), .Y_SPAN(YS), .WRAP_X(1)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .move_dir(move_dir),
        .init_x(init_x), .init_y(init_y), .map_if(mif0),
        .pos_x(pos_x[0]), .pos_y(pos_y[0]),
        .busy(busy_o[0]), .done(done_o[0]), .overrun(ovr_o[0])
    );

    sprite_motion_engine #(
        .NUM_SPRITES(NS), .X_W(XW), .Y_W(YW), .STEP(STEP),
        .X_SPAN(XS), .Y_SPAN(YS), .WRAP_X(0)
    ) dut_nw (
        .clk(clk), .rst(rst), .tick(tick), .move_dir(move_dir),
        .init_x(init_x), .init_y(init_y), .map_if(mif1),
        .pos_x(pos_x[1]), .pos_y(pos_y[1]),
        .busy(busy_o[1]), .done(done_o[1]), .overrun(ovr_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_px(input int d, input int i);
        return 32'(pos_x[d][i*XW +: XW]);
    endfunction

    function automatic logic [31:0] dut_py(input int d, input int i);
        return 32'(pos_y[d][i*YW +: YW]);
    endfunction

    // Movement rules in signed integer arithmetic, independent of bit widths.
    function automatic void model_move(input int x, input int y, input logic [3:0] d,
                                       input logic [3:0] m, input bit wrap,
                                       output int nx, output int ny);
        nx = x;
        ny = y;
        if ($countones(d) != 1 || (d & m) == 4'b0000) return;
        case (d)
            4'b0001: begin nx = x + STEP; if (nx >= XS) nx = wrap ? nx - XS : x; end
            4'b1000: begin nx = x - STEP; if (nx < 0)   nx = wrap ? nx + XS : x; end
            4'b0010: begin ny = y - STEP; if (ny < 0)   ny = y; end
            4'b0100: begin ny = y + STEP; if (ny >= YS) ny = y; end
            default: ;
        endcase
    endfunction

    task automatic apply_cfg();
        for (int i = 0; i < NS; i++) begin
            move_dir[i*4 +: 4]  = dir_a[i];
            init_x[i*XW +: XW]  = XW'(ix[i]);
            init_y[i*YW +: YW]  = YW'(iy[i]);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s busy[%0d]", tag, d), busy_o[d], 0);
            chk($sformatf("%s done[%0d]", tag, d), done_o[d], 0);
            chk($sformatf("%s overrun[%0d]", tag, d), ovr_o[d], 0);
            chk($sformatf("%s map_req[%0d]", tag, d), req_o[d], 0);
            chk($sformatf("%s map_x[%0d]", tag, d), mx_o[d], 0);
            chk($sformatf("%s map_y[%0d]", tag, d), my_o[d], 0);
            for (int i = 0; i < NS; i++) begin
                chk($sformatf("%s pos_x[%0d][%0d]", tag, d, i), dut_px(d, i), ix[i]);
                chk($sformatf("%s pos_y[%0d][%0d]", tag, d, i), dut_py(d, i), iy[i]);
                mpx[d][i] = ix[i];
                mpy[d][i] = iy[i];
            end
        end
        exp_ovr = 0;
    endtask

    task automatic do_reset();
        apply_cfg();
        tick = 1'b0;
        ack  = 1'b0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
    endtask

    // One tick-initiated pass. tick_at: cycle to send an extra tick (-1 none);
    // tick_in_done: send a tick in the DONE cycle; abort_k: sprite whose request
    // is interrupted by reset (-1 none); spurious: random acks outside requests.
    task automatic run_pass(input int tick_at, input bit tick_in_done,
                            input int abort_k, input bit spurious);
        int k = 0;
        int wait_c = 0;
        int next_req = 1;
        int last_ack = -100;
        int exp_lat = 2*NS + 1;
        int nx, ny;
        bit finished = 0;
        bit exp_req, exp_done;
        int changes [2][NS];
        int prev_x [2][NS];
        int prev_y [2][NS];
        int start_x [2][NS];
        int start_y [2][NS];

        for (int i = 0; i < NS; i++) begin
            exp_lat += dly[i];
            for (int d = 0; d < 2; d++) begin
                changes[d][i] = 0;
                prev_x[d][i]  = mpx[d][i];
                prev_y[d][i]  = mpy[d][i];
                start_x[d][i] = mpx[d][i];
                start_y[d][i] = mpy[d][i];
            end
        end
        apply_cfg();
        tick = 1'b1;
        @(negedge clk);

        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            tick = (cyc == tick_at);
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < NS; i++)
                    if (dut_px(d, i) !== prev_x[d][i] || dut_py(d, i) !== prev_y[d][i]) begin
                        changes[d][i]++;
                        prev_x[d][i] = int'(dut_px(d, i));
                        prev_y[d][i] = int'(dut_py(d, i));
                    end
            exp_req  = (cyc >= next_req) && (k < NS);
            exp_done = (k == NS) && (cyc == last_ack + 2);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("map_req[%0d] c%0d", d, cyc), req_o[d], exp_req);
                chk($sformatf("done[%0d] c%0d", d, cyc), done_o[d], exp_done);
                chk($sformatf("busy[%0d] c%0d", d, cyc), busy_o[d], !exp_done);
                if (exp_req) begin
                    chk($sformatf("map_x[%0d] s%0d", d, k), mx_o[d], mpx[d][k]);
                    chk($sformatf("map_y[%0d] s%0d", d, k), my_o[d], mpy[d][k]);
                end
            end

            if (abort_k >= 0 && exp_req && k == abort_k && wait_c == 1) begin
                ack  = 1'b0;
                tick = 1'b0;
                rst  = 1'b1;
                @(negedge clk);
                check_reset_state("abort");
                rst = 1'b0;
                repeat (2*NS + 4) begin
                    @(negedge clk);
                    for (int d = 0; d < 2; d++) begin
                        chk($sformatf("abort done[%0d]", d), done_o[d], 0);
                        chk($sformatf("abort busy[%0d]", d), busy_o[d], 0);
                    end
                end
                return;
            end

            if (exp_req) begin
                if (wait_c == dly[k]) begin
                    ack   = 1'b1;
                    moves = mv_a[k];
                    for (int d = 0; d < 2; d++) begin
                        model_move(mpx[d][k], mpy[d][k], dir_a[k], mv_a[k], d == 0, nx, ny);
                        mpx[d][k] = nx;
                        mpy[d][k] = ny;
                    end
                    last_ack = cyc;
                    next_req = cyc + 2;
                    k++;
                    wait_c = 0;
                end else begin
                    ack = 1'b0;
                    wait_c++;
                end
            end else begin
                ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
                moves = 4'($urandom_range(0, 15));
            end

            if (exp_done) begin
                if (tick_in_done) tick = 1'b1;
                chk("latency", cyc, exp_lat);
                finished = 1;
            end
            if (tick) exp_ovr = 1;
            @(negedge clk);
        end

        tick = 1'b0;
        ack  = 1'b0;
        chk("done_seen", finished, 1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("post done[%0d]", d), done_o[d], 0);
            chk($sformatf("post busy[%0d]", d), busy_o[d], 0);
            chk($sformatf("post map_req[%0d]", d), req_o[d], 0);
            chk($sformatf("overrun[%0d]", d), ovr_o[d], exp_ovr);
            for (int i = 0; i < NS; i++) begin
                chk($sformatf("pos_x[%0d][%0d]", d, i), dut_px(d, i), mpx[d][i]);
                chk($sformatf("pos_y[%0d][%0d]", d, i), dut_py(d, i), mpy[d][i]);
                chk($sformatf("updates[%0d][%0d]", d, i), changes[d][i],
                    (mpx[d][i] != start_x[d][i] || mpy[d][i] != start_y[d][i]) ? 1 : 0);
            end
        end
    endtask

    task automatic randomize_inits();
        for (int i = 0; i < NS; i++) begin
            ix[i] = $urandom_range(0, XS - 1);
            iy[i] = $urandom_range(0, YS - 1);
        end
    endtask

    initial begin
        // Basic move and right-edge tunnel wrap.
        randomize_inits();
        ix[0] = 10;  iy[0] = 10;
        ix[1] = 405; iy[1] = 100;
        for (int i = 0; i < NS; i++) begin
            dir_a[i] = 4'b0000; mv_a[i] = 4'($urandom_range(0, 15)); dly[i] = 0;
        end
        dir_a[0] = 4'b0001; mv_a[0] = 4'b0001; dly[0] = 1;
        dir_a[1] = 4'b0001; mv_a[1] = 4'b0001;
        do_reset();
        run_pass(-1, 0, -1, 0);
        chk("s0 x wrap", dut_px(0, 0), 25);
        chk("s0 y wrap", dut_py(0, 0), 10);
        chk("s1 x wrap", dut_px(0, 1), 0);
        chk("s1 x nowrap", dut_px(1, 1), 405);
        chk("s1 y nowrap", dut_py(1, 1), 100);

        // Blocked UP at the top edge, then a non-one-hot direction.
        ix[0] = 30; iy[0] = 5;
        dir_a[0] = 4'b0010; mv_a[0] = 4'b0010; dly[0] = 0;
        dir_a[1] = 4'b0000;
        do_reset();
        run_pass(-1, 0, -1, 0);
        chk("up blocked y", dut_py(0, 0), 5);
        dir_a[0] = 4'b0011; mv_a[0] = 4'b1111;
        run_pass(-1, 0, -1, 0);
        chk("two-hot x", dut_px(0, 0), 30);
        chk("two-hot y", dut_py(0, 0), 5);

        // Edge cases on every boundary.
        ix = '{5, 15, 100, 404, 404};
        iy = '{200, 15, 14, 449, 450};
        dir_a = '{4'b1000, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
        mv_a  = '{4'b1000, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
        dly   = '{0, 0, 0, 0, 0};
        do_reset();
        run_pass(-1, 0, -1, 1);
        chk("left wrap x", dut_px(0, 0), 410);
        chk("left nowrap x", dut_px(1, 0), 5);

        // Ack delays 0/3/7 with random directions.
        dly = '{0, 3, 7, 0, 3};
        for (int i = 0; i < NS; i++) begin
            dir_a[i] = 4'(1 << $urandom_range(0, 3));
            mv_a[i]  = 4'($urandom_range(0, 15));
        end
        run_pass(-1, 0, -1, 1);

        // Tick while busy: pass unaffected, overrun sticky until reset.
        run_pass(4, 0, -1, 0);
        run_pass(-1, 0, -1, 0);
        do_reset();
        run_pass(-1, 1, -1, 0);

        // Reset during sprite 2's request, then a normal pass.
        do_reset();
        dly = '{0, 0, 5, 0, 0};
        run_pass(-1, 0, 2, 0);
        run_pass(-1, 0, -1, 0);

        // Randomized passes.
        for (int p = 0; p < 20; p++) begin
            if (p % 5 == 0) begin
                randomize_inits();
                do_reset();
            end
            for (int i = 0; i < NS; i++) begin
                dir_a[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                        : 4'(1 << $urandom_range(0, 3));
                mv_a[i]  = 4'($urandom_range(0, 15));
                dly[i]   = $urandom_range(0, 4);
            end
            run_pass(-1, 0, -1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
